// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial packed-BCD adder, one digit per clock.
// Operands enter on an in_valid/in_ready handshake. They are processed
// least-significant digit first through a single 4-bit adder with +6
// decimal correction. The result is held on an out_valid/out_ready handshake.
// Optional feature macro: BCD_SUB_EN enables A-B by nine's-complement addition.
// When the macro is undefined, the sub port is present but ignored.

module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Control and result registers (reset)
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_err;
  logic             r_in_ready;
  logic             r_out_valid;

  // Operand shift registers and running carry (data only, no reset)
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_c;

  // Digit datapath
  logic [3:0]       w_a_dig;
  logic [3:0]       w_b_raw;
  logic [3:0]       w_b_eff;
  logic [4:0]       w_dsum;
  logic             w_dig_bad;
  logic             w_accept;
  logic             w_c_init;

  // One decimal digit add: binary sum, then +6 correction when above 9.
  // Returns {carry, digit}. The 5-bit intermediate holds up to 15+15+1.
  function automatic logic [4:0] bcd_digit_add(
    input logic [3:0] da,
    input logic [3:0] db,
    input logic       ci
  );
    logic [4:0] t;
    logic [4:0] tc;
    t  = {1'b0, da} + {1'b0, db} + {4'b0000, ci};
    tc = t + 5'd6;
    if (t > 5'd9) begin
      return {1'b1, tc[3:0]};
    end
    return {1'b0, t[3:0]};
  endfunction

`ifdef BCD_SUB_EN
  logic r_sub;

  // Nine's complement of one digit. Out-of-range inputs wrap mod 16;
  // those cases are flagged through err, and the result digit is don't-care.
  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    return 4'd9 - d;
  endfunction

  assign w_b_eff  = r_sub ? nines_comp(w_b_raw) : w_b_raw;
  // A subtraction starts with the inverted borrow. This supplies the +1
  // that turns the nine's complement into a ten's complement.
  assign w_c_init = sub ? ~cin : cin;
`else
  logic w_unused_sub;

  assign w_unused_sub = sub;
  assign w_b_eff      = w_b_raw;
  assign w_c_init     = cin;
`endif

  assign w_a_dig   = r_a[3:0];
  assign w_b_raw   = r_b[3:0];
  assign w_dsum    = bcd_digit_add(w_a_dig, w_b_eff, r_c);
  assign w_dig_bad = (w_a_dig > 4'd9) | (w_b_raw > 4'd9);
  assign w_accept  = in_valid & r_in_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign err       = r_err;

  // Operand capture on accept, then shift one digit per RUN cycle and carry forward
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b;
      r_c <= w_c_init;
`ifdef BCD_SUB_EN
      r_sub <= sub;
`endif
    end else if (r_state == RUN) begin
      r_a <= r_a >> 4;
      r_b <= r_b >> 4;
      r_c <= w_dsum[4];
    end
  end

  // Control FSM: accept operands, run DIGITS digit steps, hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (r_cnt == CNT_W'(i)) begin
              r_sum[4*i +: 4] <= w_dsum[3:0];
            end
          end
          r_err <= r_err | w_dig_bad;
          if (r_cnt == LAST_DIGIT) begin
            r_cout      <= w_dsum[4];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Testbench for bcd_serial_adder (DIGITS=4): directed cases plus random operands.
// Results are compared against a whole-number decimal reference model.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint pow10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    longint x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    bit bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // One full transaction: accept, latency, result, optional stall in DONE, release.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic tcin, input logic tsub, input int hold);
    longint       modv;
    longint       total;
    logic [W-1:0] es;
    logic [W-1:0] held_sum;
    logic         ec;
    logic         held_cout;
    logic         ee;
    bit           do_sub;
    int           n;

    modv   = pow10(DIGITS);
    ee     = has_bad(ta) | has_bad(tbv);
    do_sub = 1'b0;
`ifdef BCD_SUB_EN
    do_sub = tsub;
`endif
    if (do_sub) total = bcd2int(ta) - bcd2int(tbv) - longint'(tcin) + modv;
    else        total = bcd2int(ta) + bcd2int(tbv) + longint'(tcin);
    ec = (total >= modv);
    es = int2bcd(total % modv);

    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, ":in_ready_idle"}, 64'(in_ready), 64'(1));

    a = ta; b = tbv; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    check({tag, ":in_ready_busy"}, 64'(in_ready), 64'(0));

    n = 0;
    while (out_valid !== 1'b1 && n < DIGITS + 4) begin
      @(posedge clk); #1; n++;
    end
    check({tag, ":latency"}, 64'(n), 64'(DIGITS));
    check({tag, ":err"}, 64'(err), 64'(ee));
    if (!ee) begin
      check({tag, ":sum"}, 64'(sum), 64'(es));
      check({tag, ":cout"}, 64'(cout), 64'(ec));
    end
    held_sum  = sum;
    held_cout = cout;

    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; a = rand_bcd(); b = rand_bcd(); cin = 1'($urandom);
      @(posedge clk); #1;
      check({tag, ":hold_valid"}, 64'(out_valid), 64'(1));
      check({tag, ":hold_in_ready"}, 64'(in_ready), 64'(0));
      check({tag, ":hold_sum"}, 64'(sum), 64'(held_sum));
      check({tag, ":hold_cout"}, 64'(cout), 64'(held_cout));
      check({tag, ":hold_err"}, 64'(err), 64'(ee));
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ":release_valid"}, 64'(out_valid), 64'(0));
    check({tag, ":release_in_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("reset:in_ready", 64'(in_ready), 64'(1));
    check("reset:out_valid", 64'(out_valid), 64'(0));
    check("reset:sum", 64'(sum), 64'(0));
    check("reset:cout", 64'(cout), 64'(0));
    check("reset:err", 64'(err), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    run_op("op1", 16'h1234, 16'h5678, 1'b0, 1'b0, 0);
    run_op("wrap", 16'h9999, 16'h0001, 1'b0, 1'b0, 0);
    run_op("cin_only", 16'h0000, 16'h0000, 1'b1, 1'b0, 0);
    run_op("bad_digit", 16'h12A4, 16'h0001, 1'b0, 1'b0, 0);
    run_op("after_bad", 16'h0001, 16'h0001, 1'b0, 1'b0, 0);
    run_op("stall", 16'h4567, 16'h5555, 1'b1, 1'b0, 3);
    run_op("max", 16'h9999, 16'h9999, 1'b1, 1'b0, 1);
`ifdef BCD_SUB_EN
    run_op("sub_pos", 16'h0100, 16'h0017, 1'b0, 1'b1, 0);
    run_op("sub_neg", 16'h0017, 16'h0100, 1'b0, 1'b1, 0);
    run_op("sub_borrow", 16'h0100, 16'h0017, 1'b1, 1'b1, 0);
`else
    run_op("sub_ignored", 16'h0100, 16'h0017, 1'b0, 1'b1, 0);
`endif

    for (int r = 0; r < 16; r++) begin
      run_op($sformatf("rand%0d", r), rand_bcd(), rand_bcd(), 1'($urandom),
             1'($urandom), int'($urandom_range(0, 2)));
    end

    // Abort an operation after two digit steps
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort:in_ready", 64'(in_ready), 64'(1));
    check("abort:out_valid", 64'(out_valid), 64'(0));
    check("abort:sum", 64'(sum), 64'(0));
    check("abort:cout", 64'(cout), 64'(0));
    check("abort:err", 64'(err), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    run_op("op1_again", 16'h1234, 16'h5678, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
